// File: rtl/snake_game_ctrl.sv
// Game-level sequencer for the snake core: IDLE/PLAY/OVER flow, tick gating,
// wall and serial self-collision checks after each step, saturating score.
module snake_game_ctrl #(
    parameter int CELL    = 10,
    parameter int GRID_W  = 64,
    parameter int GRID_H  = 48,
    parameter int MAX_LEN = 33,
    parameter int SCORE_W = 8
) (
    input  logic                     clk_pix,
    input  logic                     reset_n,
    input  logic                     tick_in,
    input  logic                     start_n,
    input  logic                     eat_evt,
    input  logic [9:0]               head_x,
    input  logic [8:0]               head_y,
    input  logic [7:0]               length,
    input  logic [MAX_LEN*10-1:0]    body_bus_x,
    input  logic [MAX_LEN*9-1:0]     body_bus_y,
    output logic                     tick_out,
    output logic                     core_rst_n,
    output logic [2:0]               state,
    output logic [SCORE_W-1:0]       score,
    output logic                     game_over
);

    // state  | meaning
    // IDLE   | core held in soft reset, waiting for a press
    // PLAY   | core running, waiting for the next step tick
    // SETTLE | one cycle for the core to update head and body bus
    // CHECK  | wall test on the first cycle, then one body segment per cycle
    // OVER   | collision seen, core frozen, score held until a press
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    localparam int K_W = $clog2(MAX_LEN);

    localparam logic [9:0]         X_LO      = 10'(CELL);
    localparam logic [9:0]         X_HI      = 10'((GRID_W - 2) * CELL);
    localparam logic [9:0]         Y_LO      = 10'(CELL);
    localparam logic [9:0]         Y_HI      = 10'((GRID_H - 2) * CELL);
    localparam logic [K_W-1:0]     K_LAST    = K_W'(MAX_LEN - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_start_s1;
    logic               r_start_s2;
    logic               r_start_d;
    logic               r_tick_out;
    logic [K_W-1:0]     r_k;
    logic [SCORE_W-1:0] r_score;

    logic               w_press;
    logic               w_in_play;
    logic [9:0]         w_seg_x;
    logic [8:0]         w_seg_y;
    logic [9:0]         w_head_y10;
    logic [7:0]         w_k8;
    logic               w_wall_hit;
    logic               w_self_hit;
    logic               w_scan_done;

    assign w_press    = r_start_d & ~r_start_s2;
    assign w_in_play  = (r_state == S_PLAY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign w_head_y10 = {1'b0, head_y};
    assign w_k8       = 8'(r_k);

    always_comb begin
        w_seg_x = '0;
        w_seg_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_k == K_W'(i)) begin
                w_seg_x = body_bus_x[(MAX_LEN - i) * 10 - 1 -: 10];
                w_seg_y = body_bus_y[(MAX_LEN - i) * 9 - 1 -: 9];
            end
        end
    end

    // Wall test only on the first CHECK cycle (k still 1); head is stable for the whole scan.
    assign w_wall_hit  = (r_k == K_W'(1)) &&
                         ((head_x < X_LO) || (head_x > X_HI) ||
                          (w_head_y10 < Y_LO) || (w_head_y10 > Y_HI));
    // Tail segment (k = length-1) is excluded: it vacates the cell this step.
    assign w_self_hit  = (r_k != '0) && ((w_k8 + 8'd1) < length) &&
                         (w_seg_x == head_x) && ({1'b0, w_seg_y} == w_head_y10);
    assign w_scan_done = ((w_k8 + 8'd1) >= length) || (r_k == K_LAST);

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_press) w_state_nxt = S_PLAY;
            S_PLAY:   if (tick_in) w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_wall_hit || w_self_hit) begin
                    w_state_nxt = S_OVER;
                end else if (w_scan_done) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_OVER:   if (w_press) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_rst_n = 1'b0;
        game_over  = 1'b0;
        case (r_state)
            S_PLAY, S_SETTLE, S_CHECK: core_rst_n = 1'b1;
            S_OVER: begin
                core_rst_n = 1'b1;
                game_over  = 1'b1;
            end
            default: ;
        endcase
    end

    assign tick_out = r_tick_out;
    assign state    = r_state;
    assign score    = r_score;

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_start_s1 <= 1'b1;
            r_start_s2 <= 1'b1;
            r_start_d  <= 1'b1;
            r_tick_out <= 1'b0;
            r_k        <= '0;
            r_score    <= '0;
        end else begin
            r_start_s1 <= start_n;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_tick_out <= (r_state == S_PLAY) && tick_in;

            if (r_state == S_SETTLE) begin
                r_k <= K_W'(1);
            end else if ((r_state == S_CHECK) && !w_wall_hit && !w_self_hit && !w_scan_done) begin
                r_k <= r_k + K_W'(1);
            end

            if ((r_state == S_IDLE) && w_press) begin
                r_score <= '0;
            end else if (eat_evt && w_in_play && (r_score != SCORE_MAX)) begin
                r_score <= r_score + SCORE_W'(1);
            end
        end
    end

endmodule
